// File: rtl/mem_stage_ahb.sv
// mem_stage_ahb: load/store stage between execute and write-back.
//  Drives a two-phase AHB-lite style master port. The address phase lasts
//  one cycle and is held while HREADY is low. The data phase is stretched by
//  HREADY wait states. Loads are lane-aligned and sign/zero extended. Non-memory
//  ops bypass in one cycle. At most one transfer is outstanding.
//  Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned memory
//  ops (no bus transfer, misalign flag) instead of using low address bits as-is.
// Ports:
//  CLK, RST           clock, asynchronous active-high reset
//  in_valid/in_ready  upstream handshake (ready only when idle)
//  is_load, is_store, mem_para, address, value, alu_res, rd_i, write_back, flush
//                     op presented by execute
//  HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HRDATA, HREADY
//                     AHB-lite master port
//  out_valid, res, rd_o, wb_en, misalign
//                     one-cycle result towards write-back
module mem_stage_ahb #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64,
  parameter int RD_W   = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        mem_para,
  input  logic [ADDR_W-1:0] address,
  input  logic [XLEN-1:0]   value,
  input  logic [XLEN-1:0]   alu_res,
  input  logic [RD_W-1:0]   rd_i,
  input  logic              write_back,
  input  logic              flush,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [XLEN-1:0]   HWDATA,
  input  logic [XLEN-1:0]   HRDATA,
  input  logic              HREADY,
  output logic              out_valid,
  output logic [XLEN-1:0]   res,
  output logic [RD_W-1:0]   rd_o,
  output logic              wb_en,
  output logic              misalign
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_ADDR = 2'b01;
  localparam logic [1:0] S_DATA = 2'b10;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q, wr_q, wb_q;
  logic [XLEN-1:0]   data_q;
  logic [RD_W-1:0]   rd_q;

  logic              is_mem, is_wr, trap, uns_in;
  logic [1:0]        size_in;
  logic [OFF_W+2:0]  sh_amt;
  logic [7:0]        pad;
  logic [XLEN-1:0]   rd_sh, ld_top, ld_val;
  logic signed [XLEN-1:0] ld_s;

  assign is_mem  = is_load | is_store;
  assign is_wr   = is_store & ~is_load;   // load+store decodes as load
  // Doubleword access does not exist on a 32-bit bus: degrade to word.
  assign size_in = (XLEN == 32 && mem_para[1:0] == 2'b11) ? 2'b10 : mem_para[1:0];
  assign uns_in  = mem_para[2] | (size_in == 2'b11);

`ifdef MEM_MISALIGN_TRAP_EN
  logic [2:0] amask;
  assign amask = 3'((4'd1 << size_in) - 4'd1);
  assign trap  = is_mem & (|(address[2:0] & amask));
`else
  assign trap  = 1'b0;
`endif

  // Read data: move the addressed byte lane to bit 0, then extend by pushing
  // the field to the top and shifting back (arithmetic for signed loads).
  assign sh_amt = {addr_q[OFF_W-1:0], 3'b000};
  assign rd_sh  = HRDATA >> sh_amt;
  assign pad    = 8'(XLEN - (8 << size_q));
  assign ld_top = rd_sh << pad;
  assign ld_s   = $signed(ld_top) >>> pad;
  assign ld_val = uns_q ? (ld_top >> pad) : ld_s;

  assign in_ready = (state == S_IDLE);
  assign HTRANS   = (state == S_ADDR) ? 2'b10 : 2'b00;
  assign HADDR    = (state == S_ADDR) ? addr_q : '0;
  assign HWRITE   = (state == S_ADDR) & wr_q;
  assign HSIZE    = (state == S_ADDR) ? {1'b0, size_q} : 3'b000;
  assign HWDATA   = (state == S_DATA && wr_q) ? (data_q << sh_amt) : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      wr_q      <= 1'b0;
      wb_q      <= 1'b0;
      data_q    <= '0;
      rd_q      <= '0;
      out_valid <= 1'b0;
      res       <= '0;
      rd_o      <= '0;
      wb_en     <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      misalign  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && !flush) begin
            if (!is_mem) begin
              out_valid <= 1'b1;
              res       <= alu_res;
              rd_o      <= rd_i;
              wb_en     <= write_back;
            end else if (trap) begin
              out_valid <= 1'b1;
              misalign  <= 1'b1;
              res       <= '0;
              rd_o      <= '0;
              wb_en     <= 1'b0;
            end else begin
              addr_q <= address;
              size_q <= size_in;
              uns_q  <= uns_in;
              wr_q   <= is_wr;
              wb_q   <= write_back;
              data_q <= value;
              rd_q   <= rd_i;
              state  <= S_ADDR;
            end
          end
        end
        S_ADDR: if (HREADY) state <= S_DATA;
        S_DATA: begin
          if (HREADY) begin
            out_valid <= 1'b1;
            state     <= S_IDLE;
            if (wr_q) begin
              res   <= '0;
              rd_o  <= '0;
              wb_en <= 1'b0;
            end else begin
              res   <= ld_val;
              rd_o  <= rd_q;
              wb_en <= wb_q;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_ahb.sv
// Bench for mem_stage_ahb (default build, XLEN=64). The driver issues ops and
// acts as the bus slave, and it pushes the expected result into a queue. A
// separate monitor pops that queue on every out_valid.
module tb_mem_stage_ahb;
  localparam int XLEN = 64, ADDR_W = 64, RD_W = 5;

  logic CLK = 1'b0, RST = 1'b1;
  logic in_valid, in_ready, is_load, is_store, write_back, flush;
  logic [2:0] mem_para;
  logic [ADDR_W-1:0] address, HADDR;
  logic [XLEN-1:0] value, alu_res, HWDATA, HRDATA, res;
  logic [RD_W-1:0] rd_i, rd_o;
  logic [1:0] HTRANS;
  logic HWRITE, HREADY, out_valid, wb_en, misalign;
  logic [2:0] HSIZE;

  mem_stage_ahb #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RD_W(RD_W)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store), .mem_para(mem_para),
    .address(address), .value(value), .alu_res(alu_res), .rd_i(rd_i),
    .write_back(write_back), .flush(flush), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .out_valid(out_valid), .res(res), .rd_o(rd_o),
    .wb_en(wb_en), .misalign(misalign));

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic        chk_res;
    logic [63:0] res;
    logic [4:0]  rd;
    logic        wb;
  } exp_t;
  exp_t q[$];
  exp_t me;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference load: gather the addressed bytes that fit in the 8-byte lane,
  // then sign-extend by two's-complement arithmetic for signed types.
  function automatic logic [63:0] ref_load(input logic [2:0] p, input int off, input logic [63:0] rdata);
    int n;
    logic [63:0] v;
    n = 1 << p[1:0];
    v = '0;
    for (int k = 0; k < n; k++)
      if (off + k < 8) v[8*k +: 8] = rdata[8*(off+k) +: 8];
    if (!p[2] && n < 8 && v[8*n-1]) v = v - (64'd1 << (8*n));
    return v;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] v, input int off);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++)
      if (k + off < 8) w[8*(k+off) +: 8] = v[8*k +: 8];
    return w;
  endfunction

  // kind: 0 alu, 1 load, 2 store, 3 load+store (decodes as load)
  task automatic do_op(input int kind, input logic [2:0] p, input logic [63:0] a,
                       input logic [63:0] v, input logic [63:0] alu, input logic [4:0] rd,
                       input logic wb, input logic fl, input int wa, input int wd,
                       input logic [63:0] rdata);
    exp_t e;
    logic ld, st;
    ld = (kind == 1 || kind == 3);
    st = (kind == 2 || kind == 3);
    @(negedge CLK);
    chk("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; is_load = ld; is_store = st; mem_para = p; address = a;
    value = v; alu_res = alu; rd_i = rd; write_back = wb; flush = fl;
    @(posedge CLK); #1;
    // scramble inputs so any failure to latch shows up on the bus
    in_valid = 1'b0; flush = 1'b0;
    address = {$urandom, $urandom}; value = {$urandom, $urandom};
    mem_para = 3'($urandom); rd_i = 5'($urandom); write_back = 1'($urandom);
    if (fl) begin
      @(negedge CLK);
      chk("flush_no_out", out_valid, 1'b0);
      chk("flush_no_bus", HTRANS, 2'b00);
      return;
    end
    if (!ld && !st) begin
      e.cyc = cyc; e.chk_res = 1'b1; e.res = alu; e.rd = rd; e.wb = wb;
      q.push_back(e);
      return;
    end
    e.cyc = cyc + 2 + wa + wd;
    if (ld) begin
      e.chk_res = 1'b1; e.res = ref_load(p, int'(a[2:0]), rdata); e.rd = rd; e.wb = wb;
    end else begin
      e.chk_res = 1'b0; e.res = '0; e.rd = '0; e.wb = 1'b0;
    end
    q.push_back(e);
    for (int i = 0; i <= wa; i++) begin
      HREADY = (i == wa);
      @(negedge CLK);
      chk("addr_htrans", HTRANS, 2'b10);
      chk("addr_haddr", HADDR, a);
      chk("addr_hwrite", HWRITE, st && !ld);
      chk("addr_hsize", HSIZE, {1'b0, p[1:0]});
      chk("addr_busy", in_ready, 1'b0);
      @(posedge CLK); #1;
    end
    for (int j = 0; j <= wd; j++) begin
      HREADY = (j == wd);
      HRDATA = (j == wd) ? rdata : {$urandom, $urandom};
      @(negedge CLK);
      chk("data_htrans", HTRANS, 2'b00);
      if (st && !ld) chk("data_hwdata", HWDATA, ref_wdata(v, int'(a[2:0])));
      @(posedge CLK); #1;
    end
    HREADY = 1'b1;
  endtask

  // Monitor: every output beat must match the oldest expectation at its cycle.
  always @(negedge CLK) begin
    if (!RST) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out actual res=%h rd=%0d required no output", res, rd_o);
        end else begin
          me = q.pop_front();
          chk("out_cycle", 64'(cyc), 64'(me.cyc));
          chk("out_rd", rd_o, me.rd);
          chk("out_wb", wb_en, me.wb);
          chk("out_misalign", misalign, 1'b0);
          if (me.chk_res) chk("out_res", res, me.res);
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        me = q.pop_front();
        checks++; errors++;
        $display("FAIL missing_out actual none required at cycle %0d", me.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int kind, wa, wd;
    logic [2:0] p;
    in_valid = 0; is_load = 0; is_store = 0; mem_para = 0; address = 0; value = 0;
    alu_res = 0; rd_i = 0; write_back = 0; flush = 0; HRDATA = 0; HREADY = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_haddr", HADDR, 64'd0);
    chk("rst_hwrite", HWRITE, 1'b0);
    chk("rst_hsize", HSIZE, 3'd0);
    chk("rst_hwdata", HWDATA, 64'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_res", res, 64'd0);
    chk("rst_rd_o", rd_o, 5'd0);
    chk("rst_wb_en", wb_en, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_in_ready", in_ready, 1'b1);

    // directed cases
    do_op(1, 3'b000, 64'h1003, 64'h0, 64'h0, 5'd3, 1'b1, 1'b0, 0, 0, 64'h00000000_80000000);
    do_op(1, 3'b101, 64'h1006, 64'h0, 64'h0, 5'd9, 1'b1, 1'b0, 0, 2, 64'hBEEF_0000_0000_0000);
    do_op(2, 3'b010, 64'h2004, 64'h12345678, 64'h0, 5'd4, 1'b1, 1'b0, 0, 0, 64'h0);
    do_op(0, 3'b000, 64'h0, 64'h0, 64'h2A, 5'd7, 1'b1, 1'b0, 0, 0, 64'h0);
    do_op(0, 3'b000, 64'h0, 64'h0, 64'h55, 5'd8, 1'b1, 1'b1, 0, 0, 64'h0);
    do_op(1, 3'b001, 64'h4002, 64'h0, 64'h0, 5'd1, 1'b1, 1'b1, 0, 0, 64'h0);
    do_op(1, 3'b010, 64'h1006, 64'h0, 64'h0, 5'd2, 1'b1, 1'b0, 2, 1, 64'h8765_4321_FFFF_FFFF);
    do_op(1, 3'b011, 64'h5000, 64'h0, 64'h0, 5'd5, 1'b0, 1'b0, 1, 0, 64'hF000_0000_0000_0001);
    do_op(3, 3'b110, 64'h6004, 64'hAA, 64'h0, 5'd6, 1'b1, 1'b0, 0, 0, 64'h8000_0001_0000_0000);

    // reset while a load sits in a stalled data phase
    @(negedge CLK);
    in_valid = 1; is_load = 1; is_store = 0; mem_para = 3'b000; address = 64'h3001;
    rd_i = 5'd4; write_back = 1; flush = 0;
    @(posedge CLK); #1 in_valid = 0; HREADY = 1;
    @(posedge CLK); #1 HREADY = 0;
    @(negedge CLK);
    chk("stall_busy", in_ready, 1'b0);
    RST = 1'b1;
    #1;
    chk("rst_mid_htrans", HTRANS, 2'b00);
    chk("rst_mid_out_valid", out_valid, 1'b0);
    @(posedge CLK); #1 RST = 1'b0; HREADY = 1;
    @(negedge CLK);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    chk("rst_mid_no_out", out_valid, 1'b0);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 3);
      p = (kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      wa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      wd = $urandom_range(0, 2);
      do_op(kind, p, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            5'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), wa, wd,
            {$urandom, $urandom});
    end

    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
